// File: rtl/conv_result_pool.sv
// conv_result_pool: post-processing for the conv5x5 engine results.
// Per filter: ReLU, rounded right-shift requantization and unsigned
// saturation. Then max-pooling over POOL_N patches, presented on a
// valid/ready output register with a sticky overflow flag.
module conv_result_pool #(
    parameter int unsigned NUM_FILTERS = 5,
    parameter int unsigned ACC_W       = 16,
    parameter int unsigned OUT_W       = 8,
    parameter int unsigned SHIFT       = 4,
    parameter int unsigned POOL_N      = 4
) (
    input  logic                         clk_main,
    input  logic                         rst_n_main,
    input  logic [NUM_FILTERS*ACC_W-1:0] i_results_flat,
    input  logic                         i_results_valid,
    input  logic                         i_clear,
    output logic [NUM_FILTERS*OUT_W-1:0] o_pooled_flat,
    output logic                         o_pooled_valid,
    input  logic                         i_pooled_ready,
    output logic [3:0]                   o_patch_idx,
    output logic                         o_busy,
    output logic                         o_overflow
);

    localparam int unsigned EXT_W = ACC_W + 1;
    localparam int unsigned PO_W  = NUM_FILTERS * OUT_W;
    localparam int unsigned IDX_W = 4;

    localparam logic [EXT_W-1:0] ROUND    = EXT_W'(1) << (SHIFT - 1);
    localparam logic [EXT_W-1:0] SAT      = EXT_W'((1 << OUT_W) - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(POOL_N - 1);

    // One extra bit keeps x + ROUND from wrapping at the max positive value.
    function automatic logic [OUT_W-1:0] requant(input logic [ACC_W-1:0] x);
        logic [EXT_W-1:0] y;
        y = '0;
        if (!x[ACC_W-1]) begin
            y = ({1'b0, x} + ROUND) >> SHIFT;
            if (y > SAT) begin
                y = SAT;
            end
        end
        return y[OUT_W-1:0];
    endfunction

    logic                 s1_valid_q, s1_valid_d;
    logic [PO_W-1:0]      s1_data_q,  s1_data_d;
    logic [PO_W-1:0]      acc_q,      acc_d;
    logic [IDX_W-1:0]     idx_q,      idx_d;
    logic [PO_W-1:0]      out_q,      out_d;
    logic                 out_valid_q, out_valid_d;
    logic                 ovf_q,      ovf_d;

    logic [PO_W-1:0]      q_c;
    logic [PO_W-1:0]      pool_c;
    logic                 handshake_c;

    // Stage-1 datapath: requantize every filter of the incoming vector.
    always_comb begin
        q_c = '0;
        for (int k = 0; k < NUM_FILTERS; k++) begin
            q_c[k*OUT_W +: OUT_W] = requant(i_results_flat[k*ACC_W +: ACC_W]);
        end
    end

    // Stage-2 datapath: running max; first patch of a group overwrites.
    always_comb begin
        pool_c = '0;
        for (int k = 0; k < NUM_FILTERS; k++) begin
            if ((idx_q == '0) || (s1_data_q[k*OUT_W +: OUT_W] > acc_q[k*OUT_W +: OUT_W])) begin
                pool_c[k*OUT_W +: OUT_W] = s1_data_q[k*OUT_W +: OUT_W];
            end else begin
                pool_c[k*OUT_W +: OUT_W] = acc_q[k*OUT_W +: OUT_W];
            end
        end
    end

    // Next-state: pipeline capture, group counting, output register and clear.
    always_comb begin
        s1_valid_d  = i_results_valid;
        s1_data_d   = s1_data_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        ovf_d       = ovf_q;
        handshake_c = out_valid_q & i_pooled_ready;

        if (i_results_valid) begin
            s1_data_d = q_c;
        end

        if (handshake_c) begin
            out_valid_d = 1'b0;
        end

        if (s1_valid_q) begin
            acc_d = pool_c;
            if (idx_q == LAST_IDX) begin
                idx_d = '0;
                // A completed group loads only if the register is free or draining now.
                if (!out_valid_q || handshake_c) begin
                    out_d       = pool_c;
                    out_valid_d = 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end

        if (i_clear) begin
            s1_valid_d  = 1'b0;
            s1_data_d   = '0;
            acc_d       = '0;
            idx_d       = '0;
            out_d       = '0;
            out_valid_d = 1'b0;
            ovf_d       = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_main or negedge rst_n_main) begin
        if (!rst_n_main) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign o_pooled_flat  = out_q;
    assign o_pooled_valid = out_valid_q;
    assign o_patch_idx    = idx_q;
    assign o_overflow     = ovf_q;
    assign o_busy         = s1_valid_q | (idx_q != '0);

endmodule

// File: tb/tb_conv_result_pool.sv
// Directed bench for conv_result_pool with hand-computed expected values.
module tb_conv_result_pool;

    localparam int unsigned NF = 5;
    localparam int unsigned AW = 16;
    localparam int unsigned OW = 8;

    logic                clk_main = 1'b0;
    logic                rst_n_main;
    logic [NF*AW-1:0]    i_results_flat;
    logic                i_results_valid;
    logic                i_clear;
    logic [NF*OW-1:0]    o_pooled_flat;
    logic                o_pooled_valid;
    logic                i_pooled_ready;
    logic [3:0]          o_patch_idx;
    logic                o_busy;
    logic                o_overflow;

    int errors = 0;
    int checks = 0;

    int t1v[4] = '{16, 48, 32, 0};
    int t2v[4] = '{100, 200, -50, 40};
    int t4v[8] = '{16, 32, 48, 64, 32, 16, 16, 16};

    logic [11:0]      vhist;
    logic [NF*OW-1:0] d5, d9;

    always #5 clk_main = ~clk_main;

    conv_result_pool dut (
        .clk_main        (clk_main),
        .rst_n_main      (rst_n_main),
        .i_results_flat  (i_results_flat),
        .i_results_valid (i_results_valid),
        .i_clear         (i_clear),
        .o_pooled_flat   (o_pooled_flat),
        .o_pooled_valid  (o_pooled_valid),
        .i_pooled_ready  (i_pooled_ready),
        .o_patch_idx     (o_patch_idx),
        .o_busy          (o_busy),
        .o_overflow      (o_overflow)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NF*AW-1:0] pk(input int a, input int b, input int c, input int d, input int e);
        logic [NF*AW-1:0] r;
        r = {16'(e), 16'(d), 16'(c), 16'(b), 16'(a)};
        return r;
    endfunction

    function automatic logic [NF*OW-1:0] po(input int a, input int b, input int c, input int d, input int e);
        logic [NF*OW-1:0] r;
        r = {8'(e), 8'(d), 8'(c), 8'(b), 8'(a)};
        return r;
    endfunction

    // Called at a negedge; returns at the next negedge with the pulse removed.
    task automatic send(input logic [NF*AW-1:0] d);
        i_results_flat  = d;
        i_results_valid = 1'b1;
        @(negedge clk_main);
        i_results_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_main);
    endtask

    task automatic take();
        i_pooled_ready = 1'b1;
        @(negedge clk_main);
        i_pooled_ready = 1'b0;
    endtask

    initial begin
        rst_n_main      = 1'b0;
        i_results_flat  = '0;
        i_results_valid = 1'b0;
        i_clear         = 1'b0;
        i_pooled_ready  = 1'b0;
        idle(2);
        check("rst_valid", 64'(o_pooled_valid), 64'(0));
        check("rst_flat",  64'(o_pooled_flat),  64'(0));
        rst_n_main = 1'b1;
        idle(1);

        // Test 1: reset mid-group, then a fresh group.
        send(pk(16, 16, 16, 16, 16));
        check("t1_busy_s1", 64'(o_busy), 64'(1));
        check("t1_idx_a",   64'(o_patch_idx), 64'(0));
        idle(1);
        check("t1_idx_b",   64'(o_patch_idx), 64'(1));
        send(pk(16, 16, 16, 16, 16));
        idle(1);
        check("t1_idx_c",   64'(o_patch_idx), 64'(2));
        #2 rst_n_main = 1'b0;
        #1;
        check("t1_rst_idx",   64'(o_patch_idx), 64'(0));
        check("t1_rst_busy",  64'(o_busy), 64'(0));
        check("t1_rst_valid", 64'(o_pooled_valid), 64'(0));
        check("t1_rst_ovf",   64'(o_overflow), 64'(0));
        check("t1_rst_flat",  64'(o_pooled_flat), 64'(0));
        @(negedge clk_main);
        rst_n_main = 1'b1;
        idle(1);
        for (int p = 0; p < 4; p++) begin
            send(pk(t1v[p], 0, 0, 0, 0));
            idle(1);
            check("t1_idx_seq", 64'(o_patch_idx), 64'((p + 1) % 4));
        end
        check("t1_valid", 64'(o_pooled_valid), 64'(1));
        check("t1_data",  64'(o_pooled_flat), 64'(po(3, 0, 0, 0, 0)));
        take();
        check("t1_drained", 64'(o_pooled_valid), 64'(0));

        // Test 2: ReLU, rounding and max with spaced pulses.
        for (int p = 0; p < 4; p++) begin
            send(pk(t2v[p], 0, 0, 0, 0));
            if (p < 3) idle(9);
        end
        check("t2_lat_n1", 64'(o_pooled_valid), 64'(0));
        idle(1);
        check("t2_valid", 64'(o_pooled_valid), 64'(1));
        check("t2_data",  64'(o_pooled_flat), 64'(po(13, 0, 0, 0, 0)));
        idle(3);
        check("t2_hold_valid", 64'(o_pooled_valid), 64'(1));
        check("t2_hold_data",  64'(o_pooled_flat), 64'(po(13, 0, 0, 0, 0)));
        take();
        check("t2_drained", 64'(o_pooled_valid), 64'(0));

        // Test 3: saturation and edge values, then the 7/8 rounding boundary.
        for (int p = 0; p < 4; p++) send(pk(0, 5000, 32767, -32768, 7));
        idle(1);
        check("t3_valid", 64'(o_pooled_valid), 64'(1));
        check("t3_data",  64'(o_pooled_flat), 64'(po(0, 255, 255, 0, 0)));
        take();
        for (int p = 0; p < 4; p++) send(pk(0, 5000, 32767, -32768, (p == 2) ? 8 : 7));
        idle(1);
        check("t3_data_r8", 64'(o_pooled_flat), 64'(po(0, 255, 255, 0, 1)));
        take();

        // Test 4: eight back-to-back pulses with ready held high.
        i_pooled_ready = 1'b1;
        for (int j = 0; j < 12; j++) begin
            vhist[j] = o_pooled_valid;
            if (j == 5) d5 = o_pooled_flat;
            if (j == 9) d9 = o_pooled_flat;
            if (j < 8) begin
                i_results_flat  = pk(t4v[j], 0, 0, 0, 0);
                i_results_valid = 1'b1;
            end else begin
                i_results_valid = 1'b0;
            end
            @(negedge clk_main);
        end
        i_pooled_ready = 1'b0;
        check("t4_valid_pattern", 64'(vhist), 64'(12'h220));
        check("t4_group1", 64'(d5), 64'(po(4, 0, 0, 0, 0)));
        check("t4_group2", 64'(d9), 64'(po(2, 0, 0, 0, 0)));
        check("t4_ovf",    64'(o_overflow), 64'(0));

        // Test 5: backpressure through two groups, overflow, then recovery.
        for (int p = 0; p < 4; p++) send(pk(160, 0, 0, 0, 0));
        idle(1);
        check("t5_a_valid", 64'(o_pooled_valid), 64'(1));
        check("t5_a_data",  64'(o_pooled_flat), 64'(po(10, 0, 0, 0, 0)));
        check("t5_a_ovf",   64'(o_overflow), 64'(0));
        for (int p = 0; p < 4; p++) send(pk(320, 0, 0, 0, 0));
        idle(1);
        check("t5_b_ovf",   64'(o_overflow), 64'(1));
        check("t5_b_valid", 64'(o_pooled_valid), 64'(1));
        check("t5_b_data",  64'(o_pooled_flat), 64'(po(10, 0, 0, 0, 0)));
        take();
        check("t5_drained", 64'(o_pooled_valid), 64'(0));
        for (int p = 0; p < 4; p++) send(pk(480, 0, 0, 0, 0));
        idle(1);
        check("t5_c_valid", 64'(o_pooled_valid), 64'(1));
        check("t5_c_data",  64'(o_pooled_flat), 64'(po(30, 0, 0, 0, 0)));
        check("t5_c_ovf",   64'(o_overflow), 64'(1));

        // Test 6: clear on the 4th pulse with a pending valid and ready.
        for (int p = 0; p < 3; p++) send(pk(16, 16, 16, 16, 16));
        i_results_flat  = pk(16, 16, 16, 16, 16);
        i_results_valid = 1'b1;
        i_clear         = 1'b1;
        i_pooled_ready  = 1'b1;
        @(negedge clk_main);
        i_results_valid = 1'b0;
        i_clear         = 1'b0;
        i_pooled_ready  = 1'b0;
        check("t6_clr_valid", 64'(o_pooled_valid), 64'(0));
        check("t6_clr_flat",  64'(o_pooled_flat), 64'(0));
        check("t6_clr_idx",   64'(o_patch_idx), 64'(0));
        check("t6_clr_busy",  64'(o_busy), 64'(0));
        check("t6_clr_ovf",   64'(o_overflow), 64'(0));
        for (int p = 0; p < 4; p++) send(pk(0, 0, 0, 0, 4000));
        idle(1);
        check("t6_valid", 64'(o_pooled_valid), 64'(1));
        check("t6_data",  64'(o_pooled_flat), 64'(po(0, 0, 0, 0, 250)));
        check("t6_idx",   64'(o_patch_idx), 64'(0));
        take();
        check("t6_drained", 64'(o_pooled_valid), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_result_pool.md
Name: conv_result_pool

Overview:
Downstream post-processing stage for the 5-filter conv5x5 engine, in the clk_main domain. It captures each completed patch result vector (NUM_FILTERS signed ACC_W-bit sums) on the wrapper's done pulse and applies ReLU, rounded right-shift requantization and unsigned saturation to OUT_W bits. It max-pools POOL_N consecutive patches per filter, which gives 2x2 pooling when patches arrive in pool-window order. The pooled vector is presented on a valid/ready output register for SPI readback or a following layer.

Parameters:
NUM_FILTERS, 5, number of filter channels per result vector
ACC_W, 16, width of each signed conv result
OUT_W, 8, width of each unsigned pooled output
SHIFT, 4, requantization right-shift (1..ACC_W-1)
POOL_N, 4, patches per pooling group (2..15)

Ports:
clk_main  in  1  main clock
rst_n_main  in  1  asynchronous active-low reset
i_results_flat  in  NUM_FILTERS*ACC_W  conv results; filter k at bits [k*ACC_W +: ACC_W]
i_results_valid  in  1  one-cycle pulse, results valid this cycle; back-to-back cycles allowed
i_clear  in  1  synchronous flush of all state
o_pooled_flat  out  NUM_FILTERS*OUT_W  pooled outputs; filter k at bits [k*OUT_W +: OUT_W]
o_pooled_valid  out  1  output register holds an unconsumed group
i_pooled_ready  in  1  consumer accepts when valid & ready
o_patch_idx  out  4  patches accumulated in the current group (0..POOL_N-1)
o_busy  out  1  pipeline stage full or o_patch_idx != 0
o_overflow  out  1  sticky: a completed group was dropped because the output register was full

Behaviour:
- Reset (async) and i_clear (sync) zero every register. o_pooled_flat=0, o_pooled_valid=0, o_patch_idx=0, o_busy=0, o_overflow=0.
- i_clear has priority over everything. A same-cycle i_results_valid is discarded, and a same-cycle handshake has no further effect.
- Stage 1 (registered, on i_results_valid), per filter:
  - x signed ACC_W. If x<0, q=0.
  - Otherwise compute y=(x + 2^(SHIFT-1)) >> SHIFT in ACC_W+1 bits so that there is no wraparound at the max positive value.
  - q = min(y, 2^OUT_W-1).
- Stage 2 (cycle after stage 1 valid):
  - If o_patch_idx==0, acc[k]=q[k]; otherwise acc[k]=max(acc[k],q[k]) (unsigned compare).
  - If o_patch_idx==POOL_N-1, the group completes: o_patch_idx wraps to 0 and the final max values (including this patch) go to the output register. Otherwise o_patch_idx increments.
- Latency: input pulse at cycle N, group-completing patch → o_pooled_valid=1 and data stable from cycle N+2.
- Output register:
  - Holds data while o_pooled_valid & !i_pooled_ready; data must not change while valid is held.
  - Handshake clears valid next cycle unless a new group loads in the same cycle. In that case the new data loads and valid stays 1 (full throughput, no bubble).
  - A group completes while valid=1 and no handshake that cycle: new group discarded, output register unchanged, o_overflow set (sticky until reset/clear). Accumulation of the next group proceeds normally.
- i_pooled_ready while o_pooled_valid=0: no effect.
- o_busy is combinational from the stage-1 valid flag and o_patch_idx.
- Accumulation never stalls: input has no ready; i_results_valid every cycle must be processed with no loss.

Test Plan:
1. Reset check: assert rst_n_main mid-group after 2 patches → all outputs 0 immediately. Next 4 patches form a fresh group with o_patch_idx counting 0,1,2,3,0.
2. ReLU/round/max: filter0 results 100, 200, -50, 40 as 4 pulses spaced 10 cycles → q = 6, 13, 0, 3. o_pooled_flat[7:0]=13, valid 2 cycles after 4th pulse, held until ready.
3. Saturation/edge values: filter1 5000, filter2 32767, filter3 -32768, filter4 7 in all 4 patches → outputs 255, 255, 0, 0 (7+8=15>>4=0). A value of 8 in any patch gives 1.
4. Back-to-back throughput: 8 consecutive-cycle pulses with ready held 1 → two groups, o_pooled_valid high 1 cycle each, 4 cycles apart, o_overflow=0.
5. Backpressure/overflow: ready=0 through 2 full groups → first group data retained, o_overflow=1. Raise ready → one handshake, valid drops. Third group delivers correctly.
6. Clear collision: i_clear coincident with the 4th pulse and a pending valid → everything zero next cycle. The next 4 pulses form a complete new group.
